mem_stage_ctrl: RTL and testbench

Memory-side control for the multi-cycle core: decodes the 4-bit `stage` word from the stage scheduler and drives the single shared synchronous memory port. It issues the instruction fetch in FETCH and the load/store in the memory-enabled EXECUTE stage. It captures returned read data one cycle later into an instruction register and an aligned, sign/zero-extended load-data register for decode and writeback.

---
 rtl/mem_stage_pkg.sv | 49 ++++
 rtl/load_extend.sv | 24 ++
 rtl/mem_stage_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared stage encodings, access-size constants and FSM states for the memory-side control.
// Helpers derive access size, natural alignment and byte-lane masks from funct3.
package mem_stage_pkg;

  localparam logic [3:0] STAGE_RESET    = 4'b0000;
  localparam logic [3:0] STAGE_FETCH    = 4'b0001;
  localparam logic [3:0] STAGE_DECODE   = 4'b0010;
  localparam logic [3:0] STAGE_EXEC_MEM = 4'b0101;
  localparam logic [3:0] STAGE_EXEC     = 4'b0100;
  localparam logic [3:0] STAGE_WB       = 4'b1000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_PEND = 2'd1,
    LD_PEND = 2'd2
  } state_t;

  // funct3[1:0] carries the size: 00 byte, 01 half, anything else treated as word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return off;
      2'b01:   return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Shifts a memory word down to the addressed byte lane and sign/zero-extends it by access type.
module load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Drives the shared memory port for fetch and load/store, and captures instruction and load data.
// Build option MEM_MISALIGN_TRAP_EN: suppress misaligned accesses and raise a sticky misalign_err.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        stage,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       instr,
  output logic [31:0]       load_data,
  output logic              misalign_err
);

  state_t      state_reg, state_next;
  logic [31:0] instr_reg, load_data_reg;
  logic [1:0]  off_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  ls_off, off_eff;
  logic        is_exec_mem, access_ok, store_en, load_start;
  logic [31:0] rep_wdata, ext_data;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^pc[1:0];
  assign ls_off         = ls_addr[1:0];
  assign off_eff        = align_off(funct3, ls_off);
  assign is_exec_mem    = (stage == STAGE_EXEC_MEM);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned, misalign_err_reg;
  assign misaligned   = is_misaligned(funct3, ls_off);
  assign access_ok    = !misaligned;
  assign misalign_err = misalign_err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)
      misalign_err_reg <= 1'b0;
    else if (is_exec_mem && (is_load || is_store) && misaligned)
      misalign_err_reg <= 1'b1;
  end
`else
  assign access_ok    = 1'b1;
  assign misalign_err = 1'b0;
`endif

  // A combined load+store decode is handled purely as a store.
  assign store_en   = is_exec_mem && is_store && access_ok;
  assign load_start = is_exec_mem && is_load && !is_store && access_ok;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rep_wdata[8*gi +: 8] = (funct3[1:0] == 2'b00) ? ls_wdata[7:0] :
                                    (funct3[1:0] == 2'b01) ? ls_wdata[8*(gi%2) +: 8] :
                                                             ls_wdata[8*gi +: 8];
    end
  endgenerate

  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .off    (off_reg),
    .funct3 (funct3_reg),
    .data   (ext_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE: begin
        if (stage == STAGE_FETCH) state_next = IF_PEND;
        else if (load_start)      state_next = LD_PEND;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = pc[ADDR_W-1:2];
    mem_we    = 1'b0;
    mem_wmask = 4'b0000;
    mem_wdata = 32'h0;
    if (stage == STAGE_RESET) begin
      mem_addr = '0;
    end else if (is_exec_mem) begin
      mem_addr = ls_addr[ADDR_W-1:2];
      if (store_en) begin
        mem_we    = 1'b1;
        mem_wmask = lane_mask(funct3, off_eff);
        mem_wdata = rep_wdata;
      end
    end
  end

  assign instr     = (state_reg == IF_PEND) ? mem_rdata : instr_reg;
  assign load_data = (state_reg == LD_PEND) ? ext_data  : load_data_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_reg     <= NOP_INSTR;
      load_data_reg <= 32'h0;
      off_reg       <= 2'b00;
      funct3_reg    <= 3'b000;
    end else begin
      if (state_reg == IF_PEND) instr_reg <= mem_rdata;
      if (state_reg == LD_PEND) load_data_reg <= ext_data;
      if (state_reg == IDLE && load_start) begin
        off_reg    <= off_eff;
        funct3_reg <= funct3;
      end
`ifdef MEM_MISALIGN_TRAP_EN
      // A suppressed load still retires, so writeback must see zero.
      if (is_exec_mem && is_load && !is_store && misaligned) load_data_reg <= 32'h0;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: port vector table, hand-written multi-cycle
// sequences, and randomized traffic against a behavioural model of the memory stage.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  stage = 4'b0000;
  logic [31:0] pc = 32'h0, ls_addr = 32'h0, ls_wdata = 32'h0;
  logic        is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_we;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] instr, load_data;
  logic        misalign_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stage        (stage),
    .pc           (pc),
    .ls_addr      (ls_addr),
    .ls_wdata     (ls_wdata),
    .is_load      (is_load),
    .is_store     (is_store),
    .funct3       (funct3),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .instr        (instr),
    .load_data    (load_data),
    .misalign_err (misalign_err)
  );

  typedef struct {
    logic [3:0]  stage;
    logic [31:0] pc;
    logic [31:0] ls_addr;
    logic [31:0] wdata;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [29:0] e_addr;
    logic        e_we;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] wd, input logic ld, input logic st, input logic [2:0] f3);
    stage = s; pc = p; ls_addr = a; ls_wdata = wd; is_load = ld; is_store = st; funct3 = f3;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'b0000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // Reference load result: pick bytes with arithmetic, then extend.
  function automatic logic [31:0] ref_ext(input logic [31:0] rd, input int off, input logic [2:0] f3);
    logic [31:0] v;
    v = rd >> (8 * off);
    case (f3)
      3'b000: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'b001: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'b100: v = v & 32'hFF;
      3'b101: v = v & 32'hFFFF;
      default: ;
    endcase
    return v;
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Model state
  logic [31:0] m_instr, m_ld;
  logic        m_err;
  int          m_pend;   // 0 none, 1 fetch response due, 2 load response due
  int          m_off;
  logic [2:0]  m_f3;

  initial begin
    logic [3:0]  opts [7];
    logic [31:0] rd;
    logic        trap;
    int          sz, off, eoff;
    logic        mis, allowed, e_we;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata, e_instr, e_ld;
    logic [29:0] e_addr;

`ifdef MEM_MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif

    vecs[0]  = '{4'b0001, 32'h10, 32'h0,   32'h0,         1'b0, 1'b0, 3'b010, 30'h4,  1'b0, 4'b0000, 32'h0};
    vecs[1]  = '{4'b0101, 32'h10, 32'h102, 32'h1234,      1'b0, 1'b1, 3'b001, 30'h40, 1'b1, 4'b1100, 32'h1234_1234};
    vecs[2]  = '{4'b0101, 32'h10, 32'h103, 32'hAB,        1'b0, 1'b1, 3'b000, 30'h40, 1'b1, 4'b1000, 32'hABAB_ABAB};
    vecs[3]  = '{4'b0101, 32'h10, 32'h100, 32'hCAFE_F00D, 1'b0, 1'b1, 3'b010, 30'h40, 1'b1, 4'b1111, 32'hCAFE_F00D};
    vecs[4]  = '{4'b0100, 32'h20, 32'h100, 32'h1111,      1'b0, 1'b1, 3'b010, 30'h8,  1'b0, 4'b0000, 32'h0};
    vecs[5]  = '{4'b0010, 32'h24, 32'h100, 32'h2222,      1'b0, 1'b1, 3'b010, 30'h9,  1'b0, 4'b0000, 32'h0};
    vecs[6]  = '{4'b1000, 32'h28, 32'h100, 32'h3333,      1'b0, 1'b1, 3'b010, 30'hA,  1'b0, 4'b0000, 32'h0};
    vecs[7]  = '{4'b0000, 32'h30, 32'h100, 32'h4444,      1'b0, 1'b1, 3'b010, 30'h0,  1'b0, 4'b0000, 32'h0};
    vecs[8]  = '{4'b0101, 32'h30, 32'h101, 32'h5A,        1'b1, 1'b1, 3'b000, 30'h40, 1'b1, 4'b0010, 32'h5A5A_5A5A};
    vecs[9]  = '{4'b0101, 32'h30, 32'h200, 32'h0,         1'b1, 1'b0, 3'b010, 30'h80, 1'b0, 4'b0000, 32'h0};
    vecs[10] = '{4'b0111, 32'h44, 32'h100, 32'h6666,      1'b0, 1'b1, 3'b010, 30'h11, 1'b0, 4'b0000, 32'h0};
    vecs[11] = '{4'b0101, 32'h44, 32'h100, 32'hFFFF_BEEF, 1'b0, 1'b1, 3'b001, 30'h40, 1'b1, 4'b0011, 32'hBEEF_BEEF};

    // Reset state
    do_reset();
    rst_n = 1'b0;
    cycle();
    check("reset_instr", instr, 32'h0000_0013);
    check("reset_load_data", load_data, 32'h0);
    check("reset_err", 32'(misalign_err), 32'h0);
    check("reset_mem_addr", {2'b00, mem_addr}, 32'h0);
    check("reset_we", 32'(mem_we), 32'h0);
    check("reset_mask", 32'(mem_wmask), 32'h0);
    rst_n = 1'b1;

    // Port decode table
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].stage, vecs[i].pc, vecs[i].ls_addr, vecs[i].wdata, vecs[i].ld, vecs[i].st, vecs[i].f3);
      #1;
      check($sformatf("vec%0d_addr", i), {2'b00, mem_addr}, {2'b00, vecs[i].e_addr});
      check($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      check($sformatf("vec%0d_mask", i), 32'(mem_wmask), 32'(vecs[i].e_mask));
      if (vecs[i].e_we) check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
      cycle();
    end

    // Fetch: address in 0001, instruction in 0010, held afterwards
    do_reset();
    drive(4'b0001, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    #1;
    check("fetch_addr", {2'b00, mem_addr}, 32'h4);
    check("fetch_we", 32'(mem_we), 32'h0);
    cycle();
    drive(4'b0010, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("fetch_instr_decode", instr, 32'hDEAD_BEEF);
    cycle();
    drive(4'b0100, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    mem_rdata = 32'h1234_5678;
    cycle();
    drive(4'b1000, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    mem_rdata = 32'h0BAD_F00D;
    #1;
    check("fetch_instr_held_wb", instr, 32'hDEAD_BEEF);
    cycle();

    // LB then LBU at 0x103
    for (int k = 0; k < 2; k++) begin
      drive(4'b0101, 32'h10, 32'h103, 32'h0, 1'b1, 1'b0, (k == 0) ? 3'b000 : 3'b100);
      #1;
      check("load_addr", {2'b00, mem_addr}, 32'h40);
      check("load_we", 32'(mem_we), 32'h0);
      cycle();
      drive(4'b1000, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
      mem_rdata = 32'h8012_3456;
      #1;
      check(k == 0 ? "lb_wb" : "lbu_wb", load_data, k == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
      cycle();
      drive(4'b0010, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
      mem_rdata = 32'h7F00_0000;
      #1;
      check(k == 0 ? "lb_held" : "lbu_held", load_data, k == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
      cycle();
    end

    // Misaligned SW at 0x101
    drive(4'b0101, 32'h10, 32'h101, 32'hA5A5_5A5A, 1'b0, 1'b1, 3'b010);
    #1;
    check("sw_mis_addr", {2'b00, mem_addr}, 32'h40);
    check("sw_mis_we", 32'(mem_we), trap ? 32'h0 : 32'h1);
    check("sw_mis_mask", 32'(mem_wmask), trap ? 32'h0 : 32'hF);
    cycle();
    drive(4'b1000, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    cycle();
    cycle();
    check("sw_mis_err_sticky", 32'(misalign_err), trap ? 32'h1 : 32'h0);

    // Reset while a load response is pending
    drive(4'b0101, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0, 3'b010);
    cycle();
    rst_n = 1'b0;
    drive(4'b0000, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    mem_rdata = 32'h5555_5555;
    cycle();
    check("rst_ldpend_load_data", load_data, 32'h0);
    check("rst_ldpend_instr", instr, 32'h0000_0013);
    check("rst_ldpend_err", 32'(misalign_err), 32'h0);
    rst_n = 1'b1;
    drive(4'b1000, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    mem_rdata = 32'h7777_7777;
    #1;
    check("rst_ldpend_no_capture", load_data, 32'h0);
    cycle();
    check("rst_ldpend_no_capture_after", load_data, 32'h0);
    check("rst_ldpend_instr_after", instr, 32'h0000_0013);

    // Randomized traffic against the model
    do_reset();
    m_instr = 32'h0000_0013; m_ld = 32'h0; m_err = 1'b0; m_pend = 0; m_off = 0; m_f3 = 3'b000;
    opts = '{4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b0101, 4'b0100, 4'b1000};
    for (int c = 0; c < 400; c++) begin
      logic [2:0] f3opts [5];
      f3opts = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      stage    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : opts[$urandom_range(0, 6)];
      pc       = $urandom;
      ls_addr  = $urandom;
      ls_wdata = $urandom;
      is_load  = 1'($urandom);
      is_store = ($urandom_range(0, 3) == 0) ? 1'b1 : ~is_load;
      funct3   = f3opts[$urandom_range(0, 4)];
      mem_rdata = $urandom;
      rd = mem_rdata;
      #1;

      sz      = size_of(funct3);
      off     = int'(ls_addr[1:0]);
      mis     = (sz == 2 && (off % 2) != 0) || (sz == 4 && off != 0);
      allowed = trap ? !mis : 1'b1;
      eoff    = off - (off % sz);
      e_we    = 1'b0; e_mask = 4'b0000; e_wdata = 32'h0;
      if (stage == 4'b0000) e_addr = 30'h0;
      else if (stage == 4'b0101) begin
        e_addr = ls_addr[31:2];
        if (is_store && allowed) begin
          e_we   = 1'b1;
          e_mask = 4'(((1 << sz) - 1) << eoff);
          e_wdata = (sz == 1) ? (ls_wdata & 32'hFF) * 32'h0101_0101 :
                    (sz == 2) ? (ls_wdata & 32'hFFFF) * 32'h0001_0001 : ls_wdata;
        end
      end else e_addr = pc[31:2];
      e_instr = (m_pend == 1) ? rd : m_instr;
      e_ld    = (m_pend == 2) ? ref_ext(rd, m_off, m_f3) : m_ld;

      check("rnd_addr", {2'b00, mem_addr}, {2'b00, e_addr});
      check("rnd_we", 32'(mem_we), 32'(e_we));
      check("rnd_mask", 32'(mem_wmask), 32'(e_mask));
      if (e_we) check("rnd_wdata", mem_wdata, e_wdata);
      check("rnd_instr", instr, e_instr);
      check("rnd_load_data", load_data, e_ld);
      check("rnd_err", 32'(misalign_err), 32'(m_err));

      m_instr = e_instr;
      m_ld    = e_ld;
      if (trap && stage == 4'b0101 && (is_load || is_store) && mis) m_err = 1'b1;
      if (trap && stage == 4'b0101 && is_load && !is_store && mis) m_ld = 32'h0;
      if (m_pend != 0) m_pend = 0;
      else if (stage == 4'b0001) m_pend = 1;
      else if (stage == 4'b0101 && is_load && !is_store && allowed) begin
        m_pend = 2; m_off = eoff; m_f3 = funct3;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
